add64_seq: RTL and testbench

Multi-cycle 64-bit adder/subtractor that time-multiplexes one 16-bit ripple-carry slice (`carry_ripple_adder_16bit`) over four cycles. It latches a pair of 64-bit operands on a start handshake and feeds the slice low slice first. A carry register chains the four slices, and the block pulses `done` with the full result. It sits beside the arithmetic datapath where 64-bit add/sub is needed but area rules out a 64-bit adder.

---
 rtl/add64_seq.sv | 148 ++++++++++++++
 tb/tb_add64_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add64_seq.sv
// add64_seq: 64-bit adder/subtractor built from a single 16-bit ripple-carry
// slice reused over four cycles, low slice first. A carry register links the
// slices. The block pulses done for one cycle when the full result is ready.

// carry_ripple_adder_16bit: plain 16-bit ripple-carry adder made of full-adder
// cells. This is the only wide adder in the design.
module carry_ripple_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit; the carry ripples from bit 0 up to bit 15.
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];

endmodule

module add64_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        ready,
  output logic        done,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [1:0]  idx;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic        c_r;

  logic        accept;
  logic        last_slice;

  logic [15:0] sl_a;
  logic [15:0] sl_b;
  logic [15:0] sl_sum;
  logic        sl_cout;

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from start to ready or done.
  assign ready      = (state != S_RUN);
  assign done       = (state == S_DONE);
  assign accept     = start && ready;
  assign last_slice = (state == S_RUN) && (idx == 2'd3);

  // Operand slice mux: select the 16-bit slice of each latched operand.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    case (idx)
      2'd0: begin sl_a = a_r[15:0];  sl_b = b_r[15:0];  end
      2'd1: begin sl_a = a_r[31:16]; sl_b = b_r[31:16]; end
      2'd2: begin sl_a = a_r[47:32]; sl_b = b_r[47:32]; end
      default: begin sl_a = a_r[63:48]; sl_b = b_r[63:48]; end
    endcase
  end

  carry_ripple_adder_16bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (c_r),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: DONE accepts a new start just like IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN:  if (idx == 2'd3) state_nx = S_DONE;
      S_DONE: state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch, slice index and carry chain register.
  // Subtraction is a + ~b + 1: the operand is inverted at accept time and the
  // +1 enters as the initial carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      idx <= 2'd0;
    end else if (accept) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      c_r <= sub;
      idx <= 2'd0;
    end else if (state == S_RUN) begin
      c_r <= sl_cout;
      idx <= idx + 2'd1;
    end
  end

  // Result registers: sum is written slice by slice; cout and ovf only change
  // at the last slice, so all three hold from DONE until the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == S_RUN) begin
      sum[{idx, 4'b0000} +: 16] <= sl_sum;
      if (last_slice) begin
        cout <= sl_cout;
        ovf  <= (a_r[63] == b_r[63]) && (sl_sum[15] != a_r[63]);
      end
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// tb_add64_seq: directed-vector bench for add64_seq with hand-computed results.
module tb_add64_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        ready;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  add64_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Advance one clock edge; observe 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in the current cycle (C) and move into C+1.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic sv);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in C+1; returns the cycle offset from C at which done is seen,
  // or 0 if it never shows up within the budget.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 64'h1234; b = 64'h5678;
    step();
    step();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: ready=%b done=%b required ready=1 done=0", ready, done);
    end
    n_checks++;
    if (sum !== 64'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_res: sum=%h cout=%b ovf=%b required 0/0/0", sum, cout, ovf);
    end
    start = 1'b0;
    rst   = 1'b0;
    step();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready=%b done=%b required ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_carry_ripple();
    int bad;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      if (ready !== 1'b0 || done !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ripple_run_hs: %0d RUN cycles with ready/done set, required 0", bad);
    end
    n_checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_done_c5: done=%b ready=%b required 1/1", done, ready);
    end
    n_checks++;
    if (sum !== 64'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_result: sum=%h cout=%b ovf=%b required 0/1/0", sum, cout, ovf);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || sum !== 64'h0 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_hold: done=%b sum=%h cout=%b required 0/0/1", done, sum, cout);
    end
  endtask

  task automatic test_overflow();
    int lat;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat != 5 || sum !== 64'h8000_0000_0000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos: lat=%0d sum=%h cout=%b ovf=%b required 5/8000000000000000/0/1",
               lat, sum, cout, ovf);
    end
    step();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat != 5 || sum !== 64'h7FFF_FFFF_FFFF_FFFF || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg: lat=%0d sum=%h cout=%b ovf=%b required 5/7fffffffffffffff/1/1",
               lat, sum, cout, ovf);
    end
    step();
  endtask

  task automatic test_subtract();
    int lat;
    issue(64'd5, 64'd7, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat != 5 || sum !== 64'hFFFF_FFFF_FFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_7: lat=%0d sum=%h cout=%b ovf=%b required 5/fffffffffffffffe/0/0",
               lat, sum, cout, ovf);
    end
    step();
    issue(64'd7, 64'd5, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat != 5 || sum !== 64'd2 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_7_5: lat=%0d sum=%h cout=%b ovf=%b required 5/2/1/0",
               lat, sum, cout, ovf);
    end
    step();
  endtask

  task automatic test_start_busy();
    int bad;
    int extra;
    issue(64'h1_0000, 64'h2_0000, 1'b0);   // now in C+1
    bad = 0;
    if (ready !== 1'b0) bad++;
    step();                                // C+2: poke start while busy
    a = 64'hDEAD; b = 64'hDEAD; sub = 1'b1; start = 1'b1;
    if (ready !== 1'b0) bad++;
    step();                                // C+3
    start = 1'b0;
    if (ready !== 1'b0 || done !== 1'b0) bad++;
    step();                                // C+4
    if (ready !== 1'b0 || done !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_ready: %0d RUN cycles with ready/done set, required 0", bad);
    end
    step();                                // C+5
    n_checks++;
    if (done !== 1'b1 || sum !== 64'h3_0000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_result: done=%b sum=%h cout=%b required 1/30000/0", done, sum, cout);
    end
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_no_second_done: %0d extra done cycles, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int bad_hs;
    int sums_ok;
    a = 64'd1; b = 64'd1; sub = 1'b0; start = 1'b1;   // cycle C
    bad_hs  = 0;
    sums_ok = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (done !== ((k % 5) == 0) || ready !== ((k % 5) == 0)) bad_hs++;
      if (k == 5  && sum === 64'd2) sums_ok++;
      if (k == 10 && sum === 64'd4) sums_ok++;
      if (k == 15 && sum === 64'd6) sums_ok++;
      if (k == 1)  begin a = 64'd2; b = 64'd2; end
      if (k == 6)  begin a = 64'd3; b = 64'd3; end
      if (k == 11) start = 1'b0;
    end
    n_checks++;
    if (bad_hs != 0) begin
      n_fail++;
      $display("FAIL b2b_handshake: %0d cycles with wrong ready/done, required 0", bad_hs);
    end
    n_checks++;
    if (sums_ok != 3) begin
      n_fail++;
      $display("FAIL b2b_sums: %0d of 3 sums correct (2,4,6), required 3", sums_ok);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_after: done=%b ready=%b required 0/1", done, ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int extra;
    issue(64'h1111, 64'h2222, 1'b0);       // C+1
    step();                                // C+2
    rst = 1'b1;
    step();                                // C+3
    rst = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sum !== 64'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: ready=%b done=%b sum=%h cout=%b ovf=%b required 1/0/0/0/0",
               ready, done, sum, cout, ovf);
    end
    step();                                // C+4
    extra = (done !== 1'b0) ? 1 : 0;
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_done(lat);
    n_checks++;
    if (extra != 0 || lat != 5 || sum !== 64'h0 || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_new_op: stray_done=%0d lat=%0d sum=%h cout=%b ovf=%b required 0/5/0/1/1",
               extra, lat, sum, cout, ovf);
    end
    step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #2;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_subtract();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at 50000, required finish");
    $fatal(1, "timeout");
  end

endmodule
